// File: rtl/pim_pkg.sv
// Shared definitions for the processing-in-memory bit-serial compute path.
`timescale 1ns/1ps
package pim_pkg;

    localparam int PIM_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pim_full_sub.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
`timescale 1ns/1ps
module pim_full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/bit_serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock,
// with latched operands and borrow / zero / signed-overflow result flags.
`timescale 1ns/1ps
module bit_serial_sub
    import pim_pkg::*;
#(
    parameter int WIDTH = PIM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             op_done
);

    localparam int              IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             op_done_q, op_done_d;

    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] full_diff;

    pim_full_sub u_full_sub (
        .x    (a_q[idx_q]),
        .y    (b_q[idx_q]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        borrow_d     = borrow_q;
        partial_d    = partial_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        op_done_d    = 1'b0;

        // The MSB is still only in d_bit on the final cycle, so splice it in.
        full_diff            = partial_q;
        full_diff[WIDTH-1]   = d_bit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    borrow_d  = 1'b0;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                borrow_d         = bout_bit;
                partial_d[idx_q] = d_bit;
                if (idx_q == LAST) begin
                    diff_d       = full_diff;
                    borrow_out_d = bout_bit;
                    zero_d       = (full_diff == '0);
                    ovf_d        = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                   (a_q[WIDTH-1] ^ full_diff[WIDTH-1]);
                    op_done_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            partial_q    <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            op_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            borrow_q     <= borrow_d;
            partial_q    <= partial_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            op_done_q    <= op_done_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q == RUN);
    assign op_done    = op_done_q;

endmodule

// File: tb/tb_bit_serial_sub.sv
// Self-checking bench for bit_serial_sub: arithmetic reference model compared
// every cycle, plus directed vectors with literal expected results.
`timescale 1ns/1ps
module tb_bit_serial_sub;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] diff;
    logic         borrow_out, zero, ovf, busy, op_done;

    int tests = 0;
    int fails = 0;

    bit_serial_sub #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .ovf        (ovf),
        .busy       (busy),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed overflow from integer range, not from sign-bit algebra.
    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint r;
        longint lim;
        r   = longint'($signed(x)) - longint'($signed(y));
        lim = longint'(1) <<< (W - 1);
        return (r >= lim) || (r < -lim);
    endfunction

    // Reference model: an op accepted when idle completes WIDTH edges later.
    logic         m_busy = 0, m_done = 0, m_bo = 0, m_z = 0, m_ov = 0;
    logic [W-1:0] m_diff = '0, p_diff = '0;
    logic         p_bo = 0, p_ov = 0;
    int           m_edges = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 0; m_done <= 0; m_bo <= 0; m_z <= 0; m_ov <= 0;
            m_diff  <= '0; m_edges <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (m_edges == W - 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_diff <= p_diff;
                    m_bo   <= p_bo;
                    m_z    <= (p_diff == '0);
                    m_ov   <= p_ov;
                end else begin
                    m_edges <= m_edges + 1;
                end
            end else if (start) begin
                m_busy  <= 1;
                m_edges <= 0;
                p_diff  <= a - b;
                p_bo    <= (a < b);
                p_ov    <= signed_ovf(a, b);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc busy",       busy,       m_busy);
        check("cyc op_done",    op_done,    m_done);
        check("cyc diff",       diff,       m_diff);
        check("cyc borrow_out", borrow_out, m_bo);
        check("cyc zero",       zero,       m_z);
        check("cyc ovf",        ovf,        m_ov);
    end

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] ed, input logic ebo,
                          input logic ez, input logic eov, input string tag);
        int cyc;
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({tag, " busy first"}, busy, 1'b1);
            end
            if (cyc == 16) check({tag, " busy last"}, busy, 1'b1);
        end while (!op_done && cyc < 60);
        check({tag, " latency"}, cyc, 17);
        check({tag, " diff"}, diff, ed);
        check({tag, " borrow_out"}, borrow_out, ebo);
        check({tag, " zero"}, zero, ez);
        check({tag, " ovf"}, ovf, eov);
        @(negedge clk);
        check({tag, " busy after"}, busy, 1'b0);
        check({tag, " op_done width"}, op_done, 1'b0);
        $display("[TB] %s: a=0x%04h b=0x%04h diff=0x%04h bo=%0b z=%0b ovf=%0b lat=%0d",
                 tag, ai, bi, diff, borrow_out, zero, ovf, cyc);
    endtask

    initial begin
        int cyc, first_done, ndone;

        #1 rst = 1'b0;
        #1;
        check("reset diff", diff, 16'h0);
        check("reset busy", busy, 1'b0);
        check("reset op_done", op_done, 1'b0);
        check("reset flags", {borrow_out, zero, ovf}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_op(16'h1234, 16'h0234, 16'h1000, 0, 0, 0, "t1");
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, "t2");
        run_op(16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, "t3a");
        run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1, "t3b");

        // Operands disturbed mid-op and a start pulse while busy.
        @(negedge clk);
        a = 16'h5A5A; b = 16'h5A5A; start = 1'b1;
        first_done = 0; ndone = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) begin a = 16'hFFFF; b = 16'h1234; end
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (op_done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
        end
        check("t4 latency", first_done, 17);
        check("t4 done count", ndone, 1);
        check("t4 diff", diff, 16'h0000);
        check("t4 zero", zero, 1'b1);
        check("t4 borrow_out", borrow_out, 1'b0);
        $display("[TB] t4: diff=0x%04h z=%0b done_count=%0d", diff, zero, ndone);

        // Back-to-back: start held through the op_done cycle.
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; start = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!op_done && cyc < 60);
        check("t5a latency", cyc, 17);
        check("t5a diff", diff, 16'h000F);
        check("t5a start held", start, 1'b1);
        a = 16'h0100; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        check("t5b accepted", busy, 1'b1);
        cyc = 1;
        while (!op_done && cyc < 60) begin @(negedge clk); cyc++; end
        check("t5b latency", cyc, 17);
        check("t5b diff", diff, 16'h00FF);
        check("t5b flags", {borrow_out, zero, ovf}, 3'b000);
        $display("[TB] t5: second diff=0x%04h lat=%0d", diff, cyc);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        check("t6 async diff", diff, 16'h0);
        check("t6 async busy", busy, 1'b0);
        check("t6 async flags", {borrow_out, zero, ovf, op_done}, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (op_done || busy) ndone++;
        end
        check("t6 aborted silent", ndone, 0);
        $display("[TB] t6: reset mid-op, no completion seen");
        run_op(16'h0003, 16'h0005, 16'hFFFE, 1, 0, 0, "t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
